k_map_core: RTL and testbench
=============================

Name: k_map_core

Overview:
- Registered four-variable Boolean function evaluator implementing a sum-of-minterms function of inputs A (MSB), B, C, D (LSB).
- Default function is F(A,B,C,D) = sum m(0,1,2,4,5,6,8,9,12,13,14), which minimises to Y = C' + A'D' + BD'.
- Used as a small control-decode leaf. It samples inputs on a valid strobe and presents a registered result one cycle later, together with the decoded minterm index and a saturating count of true results.

Parameters:
- MINTERM_MASK, 16'h7377, truth table of the function. Bit i = Y for minterm index i = {A,B,C,D}.
- CNT_W, 16, width of the true-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies A..D in the current cycle.
- A  input  1  function variable, weight 8.
- B  input  1  function variable, weight 4.
- C  input  1  function variable, weight 2.
- D  input  1  function variable, weight 1.
- Y  output  1  registered function result.
- y_valid  output  1  high for one cycle when Y/minterm hold a fresh result.
- minterm  output  4  registered index {A,B,C,D} of the evaluated input.
- true_cnt  output  CNT_W  number of evaluations with Y=1, saturating.

Behaviour:
- Reset values, applied at the clk edge while rst=1: Y=0, y_valid=0, minterm=4'd0, true_cnt=0. rst has priority over in_valid in the same cycle.
- Evaluation:
  - On a clk edge with rst=0 and in_valid=1: minterm <= {A,B,C,D}; Y <= MINTERM_MASK[{A,B,C,D}]; y_valid <= 1.
  - If that Y is 1, true_cnt increments by 1.
- Latency: exactly 1 cycle from the in_valid sample to y_valid/Y.
- Throughput: one evaluation per cycle. Back-to-back in_valid yields back-to-back y_valid.
- When in_valid=0 (rst=0): y_valid <= 0. Y and minterm hold their previous values. true_cnt holds.
- X/unknown inputs are not supported. Inputs must be known whenever in_valid=1.
- true_cnt saturates at all-ones. It does not wrap and is cleared only by rst.
- With the default mask the result equals C' + A'D' + BD'. The RTL may implement it as a mask lookup or as that SOP form, but the MINTERM_MASK parameter must be honoured.
- Default truth table (index:Y): 0:1, 1:1, 2:1, 3:0, 4:1, 5:1, 6:1, 7:0, 8:1, 9:1, 10:0, 11:0, 12:1, 13:1, 14:1, 15:0.
- Reset mid-stream: a sample presented in the same cycle as rst is discarded, and no y_valid follows it.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, ABCD=0000 -> Y=0, y_valid=0, minterm=0, true_cnt=0 after release.
- Directed minterm sequence: in_valid pulses with ABCD=0000, 0001, 0010, 0110, 1000 -> each cycle after, y_valid=1, Y=1, minterm=0,1,2,6,8; true_cnt ends at 5.
- Zeros of the function: ABCD=0011, 0111, 1010, 1011, 1111 -> Y=0, minterm=3,7,10,11,15; true_cnt unchanged.
- Exhaustive sweep: back-to-back 16 indices 0..15 -> y_valid high for 16 consecutive cycles, Y matches 16'h7377 bit-by-bit, true_cnt +11.
- Hold/idle: in_valid=0 for 5 cycles after a Y=1 result -> y_valid=0, Y stays 1, minterm stays, true_cnt stable.
- Saturation with CNT_W=3: drive 10 evaluations of ABCD=0000 -> true_cnt stops at 7. Then rst=1 for one cycle -> true_cnt=0.

Source files
------------

// File: rtl/k_map_core.sv
// Registered sum-of-minterms evaluator over {A,B,C,D}, with a saturating count of true results.
// Latency: one cycle from the in_valid sample to y_valid/Y.
// Backpressure: none; it accepts one sample every cycle and has no ready signal.
module k_map_core #(
  parameter logic [15:0] MINTERM_MASK = 16'h7377,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             D,
  output logic             Y,
  output logic             y_valid,
  output logic [3:0]       minterm,
  output logic [CNT_W-1:0] true_cnt
);

  logic [3:0] idx;
  logic       y_next;

  // A mask lookup keeps the function fully set by MINTERM_MASK.
  assign idx    = {A, B, C, D};
  assign y_next = MINTERM_MASK[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      Y        <= 1'b0;
      y_valid  <= 1'b0;
      minterm  <= 4'd0;
      true_cnt <= '0;
    end else begin
      y_valid <= in_valid;
      if (in_valid) begin
        minterm <= idx;
        Y       <= y_next;
        // Saturate at all-ones; only rst clears the count.
        if (y_next && (true_cnt != {CNT_W{1'b1}}))
          true_cnt <= true_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_k_map_core.sv
// Bench for k_map_core: a table of directed vectors, a full index sweep, and a saturation run on a 3-bit counter.
module tb_k_map_core;

  typedef struct {
    string      name;
    logic       rst;
    logic       vld;
    logic [3:0] abcd;
    logic       y;
    logic       yv;
    logic [3:0] mt;
    int         cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, A, B, C, D;
  logic        Y, y_valid;
  logic [3:0]  minterm;
  logic [15:0] true_cnt;

  logic        rst2, in_valid2, A2, B2, C2, D2;
  logic        Y2, y_valid2;
  logic [3:0]  minterm2;
  logic [2:0]  true_cnt2;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  // Truth table of the default function, indexed by {A,B,C,D}.
  logic ytab[16] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 0, 1, 1, 1, 0};

  always #5 clk = ~clk;

  k_map_core dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(A), .B(B), .C(C), .D(D),
    .Y(Y), .y_valid(y_valid), .minterm(minterm), .true_cnt(true_cnt)
  );

  k_map_core #(.MINTERM_MASK(16'h7377), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst2), .in_valid(in_valid2),
    .A(A2), .B(B2), .C(C2), .D(D2),
    .Y(Y2), .y_valid(y_valid2), .minterm(minterm2), .true_cnt(true_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the next rising edge.
  task automatic drive(input logic r, input logic v, input logic [3:0] abcd);
    @(negedge clk);
    rst = r; in_valid = v; {A, B, C, D} = abcd;
    @(posedge clk);
    #1;
  endtask

  task automatic drive2(input logic r, input logic v, input logic [3:0] abcd);
    @(negedge clk);
    rst2 = r; in_valid2 = v; {A2, B2, C2, D2} = abcd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic y, input logic yv,
                         input logic [3:0] mt, input int cnt);
    chk({name, ".Y"}, 32'(Y), 32'(y));
    chk({name, ".y_valid"}, 32'(y_valid), 32'(yv));
    chk({name, ".minterm"}, 32'(minterm), 32'(mt));
    chk({name, ".true_cnt"}, 32'(true_cnt), cnt);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; in_valid = 1'b0; {A, B, C, D} = 4'd0;
    rst2 = 1'b1; in_valid2 = 1'b0; {A2, B2, C2, D2} = 4'd0;

    // name, rst, in_valid, ABCD, Y, y_valid, minterm, true_cnt
    vecs.push_back('{"rst0",  1, 1, 4'b0000, 0, 0, 4'd0,  0});
    vecs.push_back('{"rst1",  1, 1, 4'b0000, 0, 0, 4'd0,  0});
    vecs.push_back('{"m0",    0, 1, 4'b0000, 1, 1, 4'd0,  1});
    vecs.push_back('{"m1",    0, 1, 4'b0001, 1, 1, 4'd1,  2});
    vecs.push_back('{"m2",    0, 1, 4'b0010, 1, 1, 4'd2,  3});
    vecs.push_back('{"m6",    0, 1, 4'b0110, 1, 1, 4'd6,  4});
    vecs.push_back('{"m8",    0, 1, 4'b1000, 1, 1, 4'd8,  5});
    vecs.push_back('{"z3",    0, 1, 4'b0011, 0, 1, 4'd3,  5});
    vecs.push_back('{"z7",    0, 1, 4'b0111, 0, 1, 4'd7,  5});
    vecs.push_back('{"z10",   0, 1, 4'b1010, 0, 1, 4'd10, 5});
    vecs.push_back('{"z11",   0, 1, 4'b1011, 0, 1, 4'd11, 5});
    vecs.push_back('{"z15",   0, 1, 4'b1111, 0, 1, 4'd15, 5});
    vecs.push_back('{"m13",   0, 1, 4'b1101, 1, 1, 4'd13, 6});
    for (int i = 0; i < 5; i++)
      vecs.push_back('{$sformatf("idle%0d", i), 0, 0, 4'b0011, 1, 0, 4'd13, 6});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].abcd);
      chk_all(vecs[i].name, vecs[i].y, vecs[i].yv, vecs[i].mt, vecs[i].cnt);
    end

    // Back-to-back sweep of all 16 indices.
    cnt = 6;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 4'(i));
      if (ytab[i]) cnt++;
      chk_all($sformatf("sweep%0d", i), ytab[i], 1'b1, 4'(i), cnt);
    end
    chk("sweep_total", 32'(true_cnt), 32'd17);

    // A sample taken together with rst is dropped and produces no y_valid.
    drive(1'b1, 1'b1, 4'b0001);
    chk_all("midrst", 1'b0, 1'b0, 4'd0, 0);
    drive(1'b0, 1'b0, 4'b0001);
    chk_all("midrst_after", 1'b0, 1'b0, 4'd0, 0);

    // Saturation of a 3-bit counter.
    drive2(1'b1, 1'b0, 4'b0000);
    chk("sat_rst", 32'(true_cnt2), 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive2(1'b0, 1'b1, 4'b0000);
      chk($sformatf("sat%0d", i), 32'(true_cnt2), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
      chk($sformatf("sat%0d.y_valid", i), 32'(y_valid2), 32'd1);
    end
    drive2(1'b1, 1'b0, 4'b0000);
    chk("sat_clear", 32'(true_cnt2), 32'd0);
    chk("sat_clear.y_valid", 32'(y_valid2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
